pwm_bank: RTL and testbench
===========================

# pwm_bank

Multi-channel, parametrised PWM generator for the four-motor hall drive. It takes one signed (sign-magnitude) speed command per motor and produces a PWM line and a direction line for each motor driver. It improves on the single-channel 7-bit generator with configurable width and period, shadowed duty updates at period boundaries so outputs never glitch mid-period, and optional dead-time on direction reversal. It sits between the speed controller and the H-bridge driver pins.

## Interface
- `W`, 8: magnitude width per channel.
- `CH`, 4: number of motor channels.
- `PERIOD`, 255: PWM period in clocks, 2 ≤ PERIOD ≤ 2^W.
- `DEAD_PERIODS`, 2: full periods of forced-low output on a direction reversal (used only with the dead-time macro).
- `clk` in 1: system clock; all logic on its rising edge.
- `cl` in 1: reset, synchronous, active-high.
- `en` in 1: global run enable.
- `cmd` in CH*(W+1): channel i occupies bits [i*(W+1)+W : i*(W+1)]; MSB is dir, low W bits are magnitude.
- `cmd_load` in 1: single-cycle strobe that captures all of `cmd` into the pending registers.
- `out` out CH: PWM output per channel.
- `dir` out CH: direction per channel.
- `period_end` out 1: one-cycle pulse in the last clock of each period.

## Operation
- Shared counter `cnt` counts 0..PERIOD-1 and wraps. It advances only while `en`=1; when `en`=0 it holds.
- `cmd_load`=1 copies `cmd` into `pending` and sets `pend_v`. A later load overwrites `pending`; the last value wins.
- Boundary cycle: `en`=1 and `cnt`=PERIOD-1. On this cycle, if `pend_v`=1, `pending` is copied to `active` and `pend_v` is cleared.
- `cmd_load` asserted on the boundary cycle:
  - `active` takes the old `pending` contents (if `pend_v` was set).
  - The new `cmd` stays pending with `pend_v`=1 until the next boundary.
- Duty rule, per channel: `out` = (`cnt` < `mag`).
  - `mag`=0 gives 0 %.
  - `mag` ≥ PERIOD saturates to 100 %; there is no wrap or overflow.
- `en`=0: all `out` forced low, `dir` held, loads still accepted.
- Per-channel FSM, states RUN and DEAD:
  - RUN → DEAD: at a boundary where the new `active` dir differs from the current `dir`, and `DEAD_PERIODS` > 0. On entry, `dir` updates to the new direction and `out` is forced low.
  - DEAD: a per-channel counter counts boundaries. After `DEAD_PERIODS` boundaries it returns to RUN, and PWM resumes from `cnt`=0.
  - A new command arriving during DEAD is applied at the boundary as usual. If its dir flips back, the dead counter restarts.
- `cl` mid-operation aborts everything at once, including any dead interval.

## Timing
- Reset values:
  - `cnt`=0, `pending`=0, `pend_v`=0, `active`=0.
  - All FSMs in RUN.
  - `out`=0, `dir`=0, `period_end`=0.
- `out`, `dir` and `period_end` are registered: each reflects `cnt`/`active` from the previous cycle, a 1-clock latency.
- Load to effect: new duty is visible on `out` in the first cycle of the period after the next boundary. Worst case this is PERIOD+1 clocks after `cmd_load`.
- `period_end` is high for exactly one clock per period, during the clock in which `out` shows `cnt`=PERIOD-1. It is never asserted while `en`=0.

## Configuration
- `PWM_BANK_DEADTIME_EN` defined: the RUN/DEAD FSM and dead counters are built, and behaviour is as above.
- Not defined:
  - No FSM and no dead counters; `DEAD_PERIODS` is ignored.
  - `dir` and duty both switch at the boundary with no forced-low interval.

## Structure
- Package `pwm_bank_pkg` holds:
  - the `chan_state_t` enum {RUN, DEAD};
  - a `cmd_t` struct {dir, mag[W-1:0]} (or width constants if structs are not used);
  - `DEAD_CNT_W` = clog2(DEAD_PERIODS+1).
- Sub-module `pwm_bank_chan` is instantiated CH times. It contains the shadow registers, FSM, compare and output flops.
- The shared counter and `period_end` live in the top level.

## Test plan
- Reset, then `cmd`=ch0 {0, 64}, `cmd_load`, `en`=1 (W=8, PERIOD=255) → ch0 `out` high 64 of 255 clocks from the second period on; `period_end` every 255 clocks.
- `mag`=0 and `mag`=255 on ch1/ch2 → ch1 constantly 0, ch2 constantly 1, with no single-cycle glitch at the wrap.
- `cmd_load` change 64→200 mid-period → current period keeps 64 high clocks; the next period has 200.
- Dead-time build, ch3 {0,128} then {1,128} → at the boundary `dir`[3]=1, `out`[3]=0 for 2×255 clocks, then 128-high periods. Non-dead-time build → immediate switch.
- `en` dropped mid-period for 10 clocks → `out` all 0, `cnt` frozen; on resume the period completes with the remaining count.
- `cl` during a DEAD interval → next cycle all outputs 0, FSM in RUN, `cnt`=0.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: shared types and constants for the pwm_bank block.
//   chan_state_t   : per-channel RUN / DEAD state.
//   W_DEF, CH_DEF, PERIOD_DEF, DEAD_PERIODS_DEF : default build parameters.
//   DEAD_CNT_W     : dead counter width for the default DEAD_PERIODS.
//   dead_cnt_w()   : the same width rule for any DEAD_PERIODS value.
package pwm_bank_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DEAD = 1'b1
  } chan_state_t;

  localparam int W_DEF            = 8;
  localparam int CH_DEF           = 4;
  localparam int PERIOD_DEF       = 255;
  localparam int DEAD_PERIODS_DEF = 2;

  // Width needed to count 0..periods. Never zero, so that a
  // DEAD_PERIODS of 0 still yields a legal (unused) counter.
  function automatic int dead_cnt_w(input int periods);
    return (periods < 1) ? 1 : $clog2(periods + 1);
  endfunction

  localparam int DEAD_CNT_W = dead_cnt_w(DEAD_PERIODS_DEF);

endpackage

// File: rtl/pwm_bank_if.sv
// pwm_bank_if: command / output bundle between the speed controller and
// the PWM bank.
//   en         : global run enable
//   cmd        : CH packed {dir, mag[W-1:0]} commands, channel i at
//                bits [i*(W+1)+W : i*(W+1)]
//   cmd_load   : one-cycle strobe capturing cmd into the pending registers
//   out, dir   : per-channel PWM and direction lines
//   period_end : one-cycle pulse in the last output clock of each period
// master = speed controller side, slave = pwm_bank side. W and CH must
// match the parameters of the pwm_bank instance it is bound to.
interface pwm_bank_if
  import pwm_bank_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CH = CH_DEF
);

  logic                  en;
  logic [CH*(W+1)-1:0]   cmd;
  logic                  cmd_load;
  logic [CH-1:0]         out;
  logic [CH-1:0]         dir;
  logic                  period_end;

  modport master (
    output en, cmd, cmd_load,
    input  out, dir, period_end
  );

  modport slave (
    input  en, cmd, cmd_load,
    output out, dir, period_end
  );

endinterface

// File: rtl/pwm_bank_chan.sv
// pwm_bank_chan: one PWM channel of pwm_bank.
//   clk, cl    : clock and synchronous active-high reset
//   en         : global run enable
//   boundary   : last count of a running period (en=1, cnt=PERIOD-1)
//   cnt        : shared period counter
//   cmd_load   : capture strobe for cmd
//   cmd        : {dir, mag[W-1:0]} for this channel
//   out, dir   : registered PWM and direction outputs
// Holds the pending/active shadow registers so a duty change only lands
// at a period boundary. With PWM_BANK_DEADTIME_EN defined, a RUN/DEAD
// FSM forces out low for DEAD_PERIODS periods after a direction reversal.
module pwm_bank_chan
  import pwm_bank_pkg::*;
#(
  parameter int W = W_DEF
`ifdef PWM_BANK_DEADTIME_EN
  , parameter int DEAD_PERIODS = DEAD_PERIODS_DEF
  , parameter int DEAD_W       = DEAD_CNT_W
`endif
) (
  input  logic         clk,
  input  logic         cl,
  input  logic         en,
  input  logic         boundary,
  input  logic [W-1:0] cnt,
  input  logic         cmd_load,
  input  logic [W:0]   cmd,
  output logic         out,
  output logic         dir
);

  logic [W-1:0] pend_mag_reg;
  logic         pend_dir_reg;
  logic         pend_v_reg;
  logic [W-1:0] act_mag_reg;
  logic         act_dir_reg;
  logic         out_reg;
  logic         dir_reg;
  logic         run_ok;

  // Shadow registers. A load on the boundary cycle still promotes the
  // older pending value; the new command then waits for the next one.
  always_ff @(posedge clk) begin
    if (cl) begin
      pend_mag_reg <= '0;
      pend_dir_reg <= 1'b0;
      pend_v_reg   <= 1'b0;
      act_mag_reg  <= '0;
      act_dir_reg  <= 1'b0;
    end else begin
      if (boundary && pend_v_reg) begin
        act_mag_reg <= pend_mag_reg;
        act_dir_reg <= pend_dir_reg;
      end
      if (cmd_load) begin
        pend_mag_reg <= cmd[W-1:0];
        pend_dir_reg <= cmd[W];
        pend_v_reg   <= 1'b1;
      end else if (boundary) begin
        pend_v_reg   <= 1'b0;
      end
    end
  end

`ifdef PWM_BANK_DEADTIME_EN
  chan_state_t       state_reg, state_next;
  logic [DEAD_W-1:0] dead_cnt_reg, dead_cnt_next;
  logic              reversal;

  assign reversal = boundary && pend_v_reg && (pend_dir_reg != act_dir_reg);

  always_ff @(posedge clk) begin
    if (cl) begin
      state_reg    <= RUN;
      dead_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      dead_cnt_reg <= dead_cnt_next;
    end
  end

  // A reversal always (re)starts the dead interval, even from DEAD.
  // Otherwise each boundary spent in DEAD counts toward the exit; the
  // exit boundary is also the period wrap, so PWM resumes at cnt=0.
  always_comb begin
    state_next    = state_reg;
    dead_cnt_next = dead_cnt_reg;
    if (reversal && (DEAD_PERIODS > 0)) begin
      state_next    = DEAD;
      dead_cnt_next = '0;
    end else if (boundary && (state_reg == DEAD)) begin
      if (dead_cnt_reg == DEAD_W'(DEAD_PERIODS - 1)) begin
        state_next    = RUN;
        dead_cnt_next = '0;
      end else begin
        dead_cnt_next = dead_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    run_ok = (state_reg == RUN);
  end
`else
  assign run_ok = 1'b1;
`endif

  // Magnitudes at or above PERIOD exceed every count value, which gives
  // 100 % duty without any explicit clamp.
  always_ff @(posedge clk) begin
    if (cl) begin
      out_reg <= 1'b0;
      dir_reg <= 1'b0;
    end else begin
      out_reg <= en && run_ok && (cnt < act_mag_reg);
      dir_reg <= act_dir_reg;
    end
  end

  assign out = out_reg;
  assign dir = dir_reg;

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: CH-channel sign-magnitude PWM generator for the motor drive.
//   clk : system clock (rising edge)
//   cl  : synchronous active-high reset
//   bus : pwm_bank_if.slave -- en, cmd, cmd_load in; out, dir, period_end out
// Parameters: W magnitude width, CH channels, PERIOD clocks per period
// (2..2^W), and DEAD_PERIODS forced-low periods on a direction reversal,
// which exists only when PWM_BANK_DEADTIME_EN is defined.
// The shared period counter and period_end live here; each channel is a
// pwm_bank_chan instance.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int CH     = CH_DEF,
  parameter int PERIOD = PERIOD_DEF
`ifdef PWM_BANK_DEADTIME_EN
  , parameter int DEAD_PERIODS = DEAD_PERIODS_DEF
`endif
) (
  input  logic      clk,
  input  logic      cl,
  pwm_bank_if.slave bus
);

  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0]  cnt_reg;
  logic          period_end_reg;
  logic          boundary;
  logic [CH-1:0] out_vec;
  logic [CH-1:0] dir_vec;

  assign boundary = bus.en && (cnt_reg == LAST);

  // Counter holds while disabled; period_end is the registered boundary,
  // so it lines up with the output clock that shows cnt=PERIOD-1.
  always_ff @(posedge clk) begin
    if (cl) begin
      cnt_reg        <= '0;
      period_end_reg <= 1'b0;
    end else begin
      period_end_reg <= boundary;
      if (bus.en) begin
        cnt_reg <= boundary ? '0 : cnt_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    pwm_bank_chan #(
      .W            (W)
`ifdef PWM_BANK_DEADTIME_EN
      , .DEAD_PERIODS (DEAD_PERIODS)
      , .DEAD_W       (dead_cnt_w(DEAD_PERIODS))
`endif
    ) u_chan (
      .clk      (clk),
      .cl       (cl),
      .en       (bus.en),
      .boundary (boundary),
      .cnt      (cnt_reg),
      .cmd_load (bus.cmd_load),
      .cmd      (bus.cmd[gi*(W+1) +: (W+1)]),
      .out      (out_vec[gi]),
      .dir      (dir_vec[gi])
    );
  end

  assign bus.out        = out_vec;
  assign bus.dir        = dir_vec;
  assign bus.period_end = period_end_reg;

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: self-checking bench for pwm_bank (W=8, CH=4, PERIOD=255).
// A period-level reference model is stepped once per clock and every
// output is compared each cycle; directed phases pin the model with
// hand-computed duty counts and period lengths, then a randomized phase
// exercises loads, enable drops, reversals and resets.
// Works with and without PWM_BANK_DEADTIME_EN.
module tb_pwm_bank;
  import pwm_bank_pkg::*;

  localparam int W      = 8;
  localparam int CH     = 4;
  localparam int PERIOD = 255;
`ifdef PWM_BANK_DEADTIME_EN
  localparam int DEADP = DEAD_PERIODS_DEF;
`else
  localparam int DEADP = 0;
`endif

  logic clk = 1'b0;
  logic cl;
  always #5 clk = ~clk;

  pwm_bank_if #(.W(W), .CH(CH)) bus ();

  pwm_bank #(.W(W), .CH(CH), .PERIOD(PERIOD)) dut (
    .clk (clk),
    .cl  (cl),
    .bus (bus)
  );

  // reference model state
  int m_cnt;
  int m_pmag [CH];
  int m_amag [CH];
  bit m_pdir [CH];
  bit m_adir [CH];
  bit m_pv;
  int m_dead [CH];   // whole periods of forced-low output still owed

  // statistics and per-period observations
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pe_count = 0;
  int acc_hi [CH];
  int acc_len;
  int last_hi [CH];
  int last_len;

  logic [CH*(W+1)-1:0] cmd_word;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_pv  = 0;
    for (int i = 0; i < CH; i++) begin
      m_pmag[i] = 0; m_amag[i] = 0; m_pdir[i] = 0; m_adir[i] = 0; m_dead[i] = 0;
      acc_hi[i] = 0;
    end
    acc_len = 0;
  endtask

  // One clock: the inputs seen here are those the DUT sampled at this edge.
  task automatic step();
    logic [CH-1:0] e_out, e_dir;
    logic          e_pe;
    @(posedge clk);
    #1;
    cyc++;
    e_out = '0; e_dir = '0; e_pe = 1'b0;
    if (cl) begin
      model_reset();
    end else begin
      for (int i = 0; i < CH; i++) begin
        e_out[i] = bus.en && (m_dead[i] == 0) && (m_cnt < m_amag[i]);
        e_dir[i] = m_adir[i];
      end
      e_pe = bus.en && (m_cnt == PERIOD - 1);
      if (e_pe) begin
        for (int i = 0; i < CH; i++) begin
          if (m_pv && (m_pdir[i] != m_adir[i]) && (DEADP > 0)) m_dead[i] = DEADP;
          else if (m_dead[i] > 0) m_dead[i]--;
          if (m_pv) begin
            m_adir[i] = m_pdir[i];
            m_amag[i] = m_pmag[i];
          end
        end
        m_pv = 0;
      end
      if (bus.cmd_load) begin
        for (int i = 0; i < CH; i++) begin
          m_pdir[i] = bus.cmd[i*(W+1)+W];
          m_pmag[i] = int'(bus.cmd[i*(W+1) +: W]);
        end
        m_pv = 1;
      end
      if (bus.en) m_cnt = (m_cnt + 1) % PERIOD;
    end
    chk("out", int'(bus.out), int'(e_out));
    chk("dir", int'(bus.dir), int'(e_dir));
    chk("period_end", int'(bus.period_end), int'(e_pe));
    if (!cl) begin
      for (int i = 0; i < CH; i++) acc_hi[i] += int'(bus.out[i]);
      acc_len++;
      if (bus.period_end) begin
        for (int i = 0; i < CH; i++) begin
          last_hi[i] = acc_hi[i];
          acc_hi[i]  = 0;
        end
        last_len = acc_len;
        acc_len  = 0;
        pe_count++;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_pe(input int n);
    for (int k = 0; k < n; k++) begin
      int start;
      int budget;
      start  = pe_count;
      budget = 0;
      while (pe_count == start && budget < 1000) begin
        step();
        budget++;
      end
      if (pe_count == start) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_pe: no period_end within %0d cycles (cycle %0d)", budget, cyc);
      end
    end
  endtask

  task automatic set_cmd(input int ch, input bit d, input int mag);
    cmd_word[ch*(W+1) +: (W+1)] = {d, W'(mag)};
    bus.cmd = cmd_word;
  endtask

  task automatic load();
    bus.cmd_load = 1'b1;
    step();
    bus.cmd_load = 1'b0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mags [5];
    cl = 1'b1;
    bus.en = 1'b0;
    bus.cmd_load = 1'b0;
    cmd_word = '0;
    bus.cmd = cmd_word;
    for (int i = 0; i < CH; i++) last_hi[i] = -1;
    last_len = -1;
    model_reset();

    // reset state
    steps(3);
    chk("reset_out", int'(bus.out), 0);
    chk("reset_dir", int'(bus.dir), 0);
    chk("reset_period_end", int'(bus.period_end), 0);
    cl = 1'b0;

    // basic duty, 0 % and saturated 100 %
    set_cmd(0, 0, 64);
    set_cmd(1, 0, 0);
    set_cmd(2, 0, 255);
    set_cmd(3, 0, 128);
    bus.en = 1'b1;
    load();
    wait_pe(2);
    chk("duty64_ch0", last_hi[0], 64);
    chk("duty0_ch1", last_hi[1], 0);
    chk("duty255_ch2", last_hi[2], 255);
    chk("duty128_ch3", last_hi[3], 128);
    chk("period_len", last_len, 255);

    // mid-period change lands only after the next boundary
    steps(100);
    set_cmd(0, 0, 200);
    load();
    wait_pe(1);
    chk("midchg_old", last_hi[0], 64);
    wait_pe(1);
    chk("midchg_new", last_hi[0], 200);

    // direction reversal on ch3
    steps(50);
    set_cmd(3, 1, 128);
    load();
    wait_pe(1);
    chk("rev_before", last_hi[3], 128);
    step();
    chk("rev_dir", int'(bus.dir[3]), 1);
    wait_pe(1);
    chk("rev_p1", last_hi[3], (DEADP >= 1) ? 0 : 128);
    wait_pe(1);
    chk("rev_p2", last_hi[3], (DEADP >= 2) ? 0 : 128);
    wait_pe(1);
    chk("rev_after", last_hi[3], 128);

    // enable drop freezes the counter and forces outputs low
    steps(50);
    bus.en = 1'b0;
    steps(10);
    chk("en_low_out", int'(bus.out), 0);
    bus.en = 1'b1;
    wait_pe(1);
    chk("en_pause_len", last_len, 265);
    chk("en_pause_duty", last_hi[0], 200);

    // reset in the middle of a (possible) dead interval
    steps(30);
    set_cmd(3, 0, 128);
    load();
    wait_pe(1);
    steps(20);
    cl = 1'b1;
    step();
    chk("cl_out", int'(bus.out), 0);
    chk("cl_dir", int'(bus.dir), 0);
    chk("cl_period_end", int'(bus.period_end), 0);
    cl = 1'b0;
    load();
    wait_pe(2);
    chk("post_cl_ch3", last_hi[3], 128);
    chk("post_cl_ch0", last_hi[0], 200);
    chk("post_cl_len", last_len, 255);

    // randomized traffic against the model
    mags[0] = 0; mags[1] = 255; mags[2] = 254; mags[3] = 1; mags[4] = 64;
    for (int n = 0; n < 15000; n++) begin
      cl = ($urandom_range(0, 4999) == 0);
      if (bus.en && $urandom_range(0, 199) == 0) bus.en = 1'b0;
      else if (!bus.en && $urandom_range(0, 7) == 0) bus.en = 1'b1;
      bus.cmd_load = 1'b0;
      if ($urandom_range(0, 149) == 0) begin
        for (int i = 0; i < CH; i++) begin
          int mg;
          mg = ($urandom_range(0, 1) == 0) ? mags[$urandom_range(0, 4)]
                                           : int'($urandom_range(0, 255));
          set_cmd(i, 1'($urandom_range(0, 1)), mg);
        end
        bus.cmd_load = 1'b1;
      end
      step();
    end
    bus.cmd_load = 1'b0;
    cl = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
